// File: rtl/ecm_imply_pkg.sv
// ecm_imply_pkg: shared constants and per-bit equations for the approximate
// carry-propagate row.
// - DEF_WIDTH / DEF_CNT_W: default lane count and error-counter width.
// - ecm_carry(y1,y2,y3,y4): error-compensated majority carry.
// - imply_sum(y1,y2): XOR built only from IMPLY (material implication) gates.
package ecm_imply_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    function automatic logic imply_gate(input logic a, input logic b);
        return ~a | b;
    endfunction

    function automatic logic ecm_carry(input logic y1, input logic y2,
                                       input logic y3, input logic y4);
        return ((y1 ^ y2) & (y3 | y4)) | (y1 & y2) | (y3 & y4);
    endfunction

    // a^b = (a->b) -> NOT(b->a), with NOT(x) = x -> 0.
    function automatic logic imply_sum(input logic y1, input logic y2);
        logic p;
        logic q;
        p = imply_gate(y1, y2);
        q = imply_gate(imply_gate(y2, y1), 1'b0);
        return imply_gate(p, q);
    endfunction

endpackage

// File: rtl/ecm_imply_if.sv
// ecm_imply_if: beat bus of the ecm_imply cell.
// - master: drives in_valid, approx_en, y1..y4; receives out_valid, sum,
//   carry, err, err_cnt.
// - slave: the cell side (the mirror of master).
interface ecm_imply_if
    import ecm_imply_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             in_valid;
    logic             approx_en;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [WIDTH-1:0] y4;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, approx_en, y1, y2, y3, y4,
        input  out_valid, sum, carry, err, err_cnt
    );

    modport slave (
        input  in_valid, approx_en, y1, y2, y3, y4,
        output out_valid, sum, carry, err, err_cnt
    );
endinterface

// File: rtl/ecm_imply_lane.sv
// ecm_imply_lane: combinational single-bit cell.
// Ports: y1, y2 operands; y3 incoming carry; y4 auxiliary input;
// approx_en selects the Imply sum; outputs sum, carry, err.
module ecm_imply_lane
    import ecm_imply_pkg::*;
(
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic y4,
    input  logic approx_en,
    output logic sum,
    output logic carry,
    output logic err
);
    logic sum_apx;
    logic sum_exact;

    assign sum_apx   = imply_sum(y1, y2);
    assign sum_exact = y1 ^ y2 ^ y3 ^ y4;
    assign sum       = approx_en ? sum_apx : sum_exact;
    assign carry     = ecm_carry(y1, y2, y3, y4);
    // The approximate sum only differs when y3 and y4 together contribute an odd bit.
    assign err       = approx_en & (y3 ^ y4);
endmodule

// File: rtl/ecm_imply.sv
// ecm_imply: WIDTH-lane registered approximate adder cell with a saturating
// count of beats carrying any approximation error.
// Ports: clk; rst_n (synchronous, active-low); bus (slave side of
// ecm_imply_if: in_valid/approx_en/y1..y4 in, out_valid/sum/carry/err/err_cnt out).
module ecm_imply
    import ecm_imply_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic        clk,
    input  logic        rst_n,
    ecm_imply_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] err_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] err_q;
    logic [CNT_W-1:0] err_cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ecm_imply_lane u_lane (
            .y1        (bus.y1[i]),
            .y2        (bus.y2[i]),
            .y3        (bus.y3[i]),
            .y4        (bus.y4[i]),
            .approx_en (bus.approx_en),
            .sum       (sum_d[i]),
            .carry     (carry_d[i]),
            .err       (err_d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            err_q       <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                err_q   <= err_d;
                if ((|err_d) && (err_cnt_q != CNT_MAX)) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ecm_imply.sv
module tb_ecm_imply;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       approx_en;
    logic [7:0] y1, y2, y3, y4;

    int checks   = 0;
    int failures = 0;

    ecm_imply_if #(.WIDTH(8), .CNT_W(16)) bus ();
    ecm_imply_if #(.WIDTH(8), .CNT_W(2))  bus_s ();

    assign bus.in_valid    = in_valid;
    assign bus.approx_en   = approx_en;
    assign bus.y1          = y1;
    assign bus.y2          = y2;
    assign bus.y3          = y3;
    assign bus.y4          = y4;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.approx_en = approx_en;
    assign bus_s.y1        = y1;
    assign bus_s.y2        = y2;
    assign bus_s.y3        = y3;
    assign bus_s.y4        = y4;

    ecm_imply #(.WIDTH(8), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    ecm_imply #(.WIDTH(8), .CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic a, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4);
        in_valid  = v;
        approx_en = a;
        y1 = a1; y2 = a2; y3 = a3; y4 = a4;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [7:0] s,
                           input logic [7:0] c, input logic [7:0] e);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
        chk({tag, ".sum"},       {24'd0, bus.sum},       {24'd0, s});
        chk({tag, ".carry"},     {24'd0, bus.carry},     {24'd0, c});
        chk({tag, ".err"},       {24'd0, bus.err},       {24'd0, e});
    endtask

    initial begin
        logic [3:0] v;
        int         ones;
        logic [7:0] r1, r2, r3;

        // Reset, with a beat presented that must be dropped.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00);
        step();
        step();
        chk_all("reset", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("reset.err_cnt",   {16'd0, bus.err_cnt},  32'd0);
        chk("reset.err_cnt_s", {30'd0, bus_s.err_cnt}, 32'd0);
        rst_n = 1'b1;

        // Exhaustive lane sweep, every lane receiving the same combination.
        // Carry model: ECM carry is set whenever at least two of y1..y4 are 1.
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                v = 4'(k);
                ones = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
                drive(1'b1, 1'(m), {8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}});
                step();
                chk_all($sformatf("sweep m%0d v%0h", m, k), 1'b1,
                        (m == 1) ? {8{v[3] != v[2]}} : {8{ones % 2 == 1}},
                        {8{ones >= 2}},
                        {8{(m == 1) && (v[1] != v[0])}});
            end
        end

        // Single-lane spot check.
        drive(1'b1, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00);
        step();
        chk_all("spot_apx", 1'b1, 8'h01, 8'h01, 8'h01);

        // Full-adder equivalence.
        drive(1'b1, 1'b0, 8'hFF, 8'h0F, 8'h33, 8'h00);
        step();
        chk_all("fa_fixed", 1'b1, 8'hC3, 8'h3F, 8'h00);
        for (int n = 0; n < 6; n++) begin
            r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            drive(1'b1, 1'b0, r1, r2, r3, 8'h00);
            step();
            chk_all($sformatf("fa_rand%0d", n), 1'b1, r1 ^ r2 ^ r3,
                    (r1 & r2) | (r1 & r3) | (r2 & r3), 8'h00);
        end

        // Latency / valid pattern 1,0,1,1 then idle.
        drive(1'b1, 1'b0, 8'hAA, 8'h00, 8'h00, 8'h00);
        step();
        chk_all("lat_b0", 1'b1, 8'hAA, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 8'h55, 8'h55, 8'h55, 8'h55);
        step();
        chk_all("lat_idle0", 1'b0, 8'hAA, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'hF0, 8'h0F, 8'h00, 8'h00);
        step();
        chk_all("lat_b1", 1'b1, 8'hFF, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
        step();
        chk_all("lat_b2", 1'b1, 8'h00, 8'hFF, 8'h00);
        drive(1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78);
        step();
        chk_all("lat_idle1", 1'b0, 8'h00, 8'hFF, 8'h00);

        // Error counter: 5 erroneous approximate beats, then 3 clean ones.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 8'h00);
            step();
            chk($sformatf("cnt_err%0d", n), {16'd0, bus.err_cnt}, 32'(n));
            chk($sformatf("cnt_err%0d_s", n), {30'd0, bus_s.err_cnt}, (n < 3) ? 32'(n) : 32'd3);
        end
        chk("cnt_errbit", {24'd0, bus.err}, 32'h01);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
            step();
        end
        chk("cnt_clean_err", {24'd0, bus.err}, 32'h00);
        chk("cnt_final",   {16'd0, bus.err_cnt},  32'd5);
        chk("cnt_final_s", {30'd0, bus_s.err_cnt}, 32'd3);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h00);
        step();
        chk("cnt_hold", {16'd0, bus.err_cnt}, 32'd5);

        // Reset mid-stream with in_valid high.
        drive(1'b1, 1'b1, 8'hF0, 8'h00, 8'h0F, 8'h00);
        step();
        chk_all("mid_pre", 1'b1, 8'hF0, 8'h00, 8'h0F);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        step();
        chk_all("mid_rst", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("mid_rst.err_cnt", {16'd0, bus.err_cnt}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 8'h0C, 8'h0A, 8'h03, 8'h05);
        step();
        // y1^y2=06; carry: bits0:(0,0,1,1)=1 bit1:(0,1,1,0)=1 bit2:(1,0,0,1)=1 bit3:(1,1,0,0)=1
        chk_all("post_rst", 1'b1, 8'h06, 8'h0F, 8'h06);
        chk("post_rst.err_cnt", {16'd0, bus.err_cnt}, 32'd1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        chk("post_rst.idle_ov", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ecm_imply.md
# ecm_imply

Lane-parallel, registered approximate adder cell for the approximate 8x8 array multiplier's final carry-propagate row. It merges two functions. ECM is the error-compensated majority carry. Imply is the implication-logic approximate sum, which drops the incoming carry from the sum. The multiplier instantiates one ecm_imply per group of low-order columns, and exact full adders cover the rest. An exact mode and error tracking let verification measure the approximation.

## Interface
Parameters:
- WIDTH, 8: number of independent bit lanes.
- CNT_W, 16: width of the saturating error-beat counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  the input lanes carry a beat this cycle.
- approx_en  in  1  1 selects the Imply approximate sum; 0 selects the exact sum. Sampled with in_valid.
- y1  in  WIDTH  operand bit per lane.
- y2  in  WIDTH  operand bit per lane.
- y3  in  WIDTH  incoming carry per lane.
- y4  in  WIDTH  auxiliary compressor input per lane; tie to 0 for full-adder use.
- out_valid  out  1  registered in_valid.
- sum  out  WIDTH  registered sum per lane.
- carry  out  WIDTH  registered ECM carry per lane.
- err  out  WIDTH  registered per-lane flag: approximate sum differs from exact.
- err_cnt  out  CNT_W  count of accepted beats with any err bit set.

## Operation
Per-lane logic, applied bitwise to lane i:
- ECM carry = ((y1^y2) & (y3|y4)) | (y1&y2) | (y3&y4). With y4=0 this reduces exactly to the full-adder carry ((y1^y2)&y3)|(y1&y2).
- Imply sum = y1 ^ y2. Implement it as the IMPLY-composed XOR, so it is functionally XOR. y3 and y4 do not enter it.
- Exact sum = y1 ^ y2 ^ y3 ^ y4.
- sum = approx_en ? Imply sum : exact sum.
- err = approx_en & (y3 ^ y4), i.e. set exactly where the Imply sum and the exact sum differ.

Register update:
- When in_valid=1, register sum, carry and err for the beat. err_cnt increments by 1 if any err bit of the beat is set.
- err_cnt saturates at 2^CNT_W−1 and never wraps.
- When in_valid=0, sum, carry and err hold their previous values. err_cnt holds.
- There is no backpressure: every in_valid beat is accepted.

## Timing
- Latency is 1 cycle. Inputs sampled at edge n with in_valid=1 appear on sum, carry and err after edge n, with out_valid=1 for exactly that cycle.
- out_valid follows in_valid with a one-cycle delay every cycle. Back-to-back beats are supported at full rate.
- Reset applies at a clock edge where rst_n=0. All outputs become 0: out_valid, sum, carry, err and err_cnt.
- Reset overrides in_valid on the same edge. A beat presented during reset is dropped.
- Reset asserted while a beat is in flight clears that beat; out_valid is 0 on the next cycle.
- The first beat after reset release is accepted normally.
- Simultaneous err beat with err_cnt at its maximum: err_cnt stays at the maximum.

## Structure
- The shared package holds the default WIDTH and CNT_W constants.
- It also holds pure functions ecm_carry(y1,y2,y3,y4) and imply_sum(y1,y2), so the multiplier and the scoreboard reuse the same equations.
- One sub-module, ecm_imply_lane, is natural. It is a combinational single-bit cell computing sum, carry and err.
- The top generates WIDTH instances of ecm_imply_lane and adds the output registers, the valid pipeline and the saturating counter.

## Test plan
- Exhaustive single lane: sweep all 16 combinations of y1..y4 with approx_en=0 and with approx_en=1. Required response: carry matches the ECM equation; sum and err match the equations above. Check: y1=1, y2=0, y3=1, y4=0, approx_en=1 gives sum=1, carry=1, err=1.
- Full-adder equivalence: y4=0 and approx_en=0 over random 8-lane beats. Required response: carry is the majority of y1, y2, y3; sum = y1^y2^y3. Check: y1=0xFF, y2=0x0F, y3=0x33 gives sum=0xC3, carry=0x3F.
- Latency and valid: alternate in_valid 1,0,1,1. Required response: out_valid is 0,1,0,1,1 delayed by one cycle, and data holds in between.
- Error counter: 5 approximate beats with y3=0x01 then 3 beats with y3=0. Required response: err_cnt=5. With CNT_W=2 and 5 error beats, err_cnt=3 (saturated).
- Reset mid-stream: assert rst_n=0 for one edge with in_valid=1. Required response: all outputs 0 the next cycle, err_cnt=0, and the beat is dropped.
